// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests one word at the current PC, latches it into IR
// and advances the PC; timeouts and misaligned redirects lock into a sticky error state.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        pc_load,
  input  logic [31:0] pc_next,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic        fetch_done,
  output logic        busy,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE,
    S_ERR
  } state_t;

  // Counter holds the number of REQ cycles already spent without mem_ready.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [7:0]  wait_q, wait_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (pc_load && (pc_next[1:0] != 2'b00)) begin
          state_d = S_ERR;
        end else begin
          if (pc_load) pc_d = pc_next;
          if (fetch_start) begin
            state_d = S_REQ;
            wait_d  = '0;
          end
        end
      end
      S_REQ: begin
        // A response arriving on the last allowed cycle still completes the fetch.
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DONE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_req    = (state_q == S_REQ);
  assign mem_addr   = pc_q;
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign opcode     = ir_q[31:26];
  assign fetch_done = (state_q == S_DONE);
  assign busy       = (state_q == S_REQ) || (state_q == S_DONE);
  assign fetch_err  = (state_q == S_ERR);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: scenario tasks plus a scoreboard of
// expected IR/PC values consumed whenever fetch_done pulses.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_start = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_next = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [5:0]  opcode;
  logic        fetch_done;
  logic        busy;
  logic        fetch_err;

  instr_fetch #(.RESET_PC(32'h0000_0000), .MAX_WAIT(8)) dut (
    .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc_load(pc_load),
    .pc_next(pc_next), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .pc(pc), .ir(ir), .opcode(opcode),
    .fetch_done(fetch_done), .busy(busy), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;
  int done_count = 0;
  int push_count = 0;

  always @(negedge clk) begin
    if (!reset && fetch_done) begin
      done_count++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_done: fetch_done=1 with no fetch pending");
      end else begin
        mon_e = sb.pop_front();
        if (ir !== mon_e.ir) begin
          bad++;
          $display("FAIL sb_ir: got %h want %h", ir, mon_e.ir);
        end
        total++;
        if (pc !== mon_e.pc) begin
          bad++;
          $display("FAIL sb_pc: got %h want %h", pc, mon_e.pc);
        end
        total++;
        if (opcode !== mon_e.ir[31:26]) begin
          bad++;
          $display("FAIL sb_opcode: got %h want %h", opcode, mon_e.ir[31:26]);
        end
      end
    end
  end

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // One fetch; while waiting, drives ignored noise (misaligned pc_load, fetch_start).
  task automatic do_fetch(input logic ld, input logic [31:0] tgt, input logic [31:0] exp_addr,
                          input int delay, input logic [31:0] data,
                          output int req_cycles, output logic [31:0] addr_seen,
                          output logic busy_ok);
    exp_t e;
    pc_load = ld;
    pc_next = tgt;
    fetch_start = 1'b1;
    @(posedge clk); #1;
    pc_load = 1'b1;
    pc_next = 32'h0000_0302;
    req_cycles = 0;
    addr_seen = mem_addr;
    busy_ok = 1'b1;
    for (int i = 0; i < delay; i++) begin
      if (mem_req) req_cycles++;
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    mem_rdata = data;
    if (mem_req) req_cycles++;
    if (!busy) busy_ok = 1'b0;
    e.ir = data;
    e.pc = exp_addr + 32'd4;
    sb.push_back(e);
    push_count++;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    fetch_start = 1'b0;
    pc_load = 1'b0;
    pc_next = '0;
    mem_rdata = $urandom;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    total++; if (ir !== 32'h0) begin bad++; $display("FAIL reset_ir: got %h want %h", ir, 32'h0); end
    total++; if (opcode !== 6'h0) begin bad++; $display("FAIL reset_opcode: got %h want %h", opcode, 6'h0); end
    total++;
    if ({mem_req, fetch_done, busy, fetch_err} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: got %b want %b", {mem_req, fetch_done, busy, fetch_err}, 4'b0000);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int rc;
    logic [31:0] a;
    logic bok;
    int dc;
    dc = done_count;
    do_fetch(1'b0, '0, 32'h0, 0, 32'h2000_0005, rc, a, bok);
    total++; if (a !== 32'h0) begin bad++; $display("FAIL basic_addr: got %h want %h", a, 32'h0); end
    total++; if (rc !== 1) begin bad++; $display("FAIL basic_req_cycles: got %0d want %0d", rc, 1); end
    total++; if (fetch_done !== 1'b1) begin bad++; $display("FAIL basic_done: got %b want %b", fetch_done, 1'b1); end
    total++; if (opcode !== 6'h08) begin bad++; $display("FAIL basic_opcode: got %h want %h", opcode, 6'h08); end
    total++; if (pc !== 32'h4) begin bad++; $display("FAIL basic_pc: got %h want %h", pc, 32'h4); end
    @(posedge clk); #1;
    total++; if ({fetch_done, busy} !== 2'b00) begin bad++; $display("FAIL basic_idle: got %b want %b", {fetch_done, busy}, 2'b00); end
    total++; if (done_count !== dc + 1) begin bad++; $display("FAIL basic_pulses: got %0d want %0d", done_count - dc, 1); end
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    total++; if (ir !== 32'h2000_0005) begin bad++; $display("FAIL idle_ready_ignored: got %h want %h", ir, 32'h2000_0005); end
  endtask

  task automatic test_delayed();
    int rc;
    logic [31:0] a;
    logic bok;
    do_fetch(1'b0, '0, 32'h4, 3, 32'h8C41_0010, rc, a, bok);
    total++; if (rc !== 4) begin bad++; $display("FAIL delayed_req_cycles: got %0d want %0d", rc, 4); end
    total++; if (bok !== 1'b1) begin bad++; $display("FAIL delayed_busy: got %b want %b", bok, 1'b1); end
    total++; if (a !== 32'h4) begin bad++; $display("FAIL delayed_addr: got %h want %h", a, 32'h4); end
    total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL delayed_err: got %b want %b", fetch_err, 1'b0); end
    @(posedge clk); #1;
  endtask

  task automatic test_ready_at_limit();
    int rc;
    logic [31:0] a;
    logic bok;
    do_fetch(1'b0, '0, 32'h8, 7, 32'h0400_0777, rc, a, bok);
    total++; if (rc !== 8) begin bad++; $display("FAIL limit_req_cycles: got %0d want %0d", rc, 8); end
    total++; if ({fetch_done, fetch_err} !== 2'b10) begin bad++; $display("FAIL limit_done_err: got %b want %b", {fetch_done, fetch_err}, 2'b10); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int rc;
    int dc;
    fetch_start = 1'b1;
    @(posedge clk); #1;
    fetch_start = 1'b0;
    rc = 0;
    while (mem_req && rc < 20) begin
      rc++;
      @(posedge clk); #1;
    end
    total++; if (rc !== 8) begin bad++; $display("FAIL timeout_req_cycles: got %0d want %0d", rc, 8); end
    total++; if ({fetch_err, mem_req, busy} !== 3'b100) begin bad++; $display("FAIL timeout_flags: got %b want %b", {fetch_err, mem_req, busy}, 3'b100); end
    dc = done_count;
    fetch_start = 1'b1; pc_load = 1'b1; pc_next = 32'h40; mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
    repeat (4) @(posedge clk);
    #1;
    fetch_start = 1'b0; pc_load = 1'b0; pc_next = '0; mem_ready = 1'b0;
    total++; if (fetch_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want %b", fetch_err, 1'b1); end
    total++; if (pc !== 32'hC) begin bad++; $display("FAIL err_pc_hold: got %h want %h", pc, 32'hC); end
    total++; if (ir !== 32'h0400_0777) begin bad++; $display("FAIL err_ir_hold: got %h want %h", ir, 32'h0400_0777); end
    total++; if (done_count !== dc) begin bad++; $display("FAIL err_no_done: got %0d want %0d", done_count - dc, 0); end
    apply_reset();
    total++; if ({fetch_err, pc} !== {1'b0, 32'h0}) begin bad++; $display("FAIL err_reset_clear: got %b/%h want 0/00000000", fetch_err, pc); end
  endtask

  task automatic test_redirect();
    int rc;
    logic [31:0] a;
    logic bok;
    do_fetch(1'b1, 32'h0000_0100, 32'h0000_0100, 1, 32'h0000_0123, rc, a, bok);
    total++; if (a !== 32'h100) begin bad++; $display("FAIL redirect_addr: got %h want %h", a, 32'h100); end
    total++; if (pc !== 32'h104) begin bad++; $display("FAIL redirect_pc: got %h want %h", pc, 32'h104); end
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned();
    pc_load = 1'b1;
    pc_next = 32'h0000_0102;
    fetch_start = 1'b1;
    @(posedge clk); #1;
    pc_load = 1'b0;
    fetch_start = 1'b0;
    total++; if ({fetch_err, mem_req} !== 2'b10) begin bad++; $display("FAIL misaligned_flags: got %b want %b", {fetch_err, mem_req}, 2'b10); end
    total++; if (pc !== 32'h104) begin bad++; $display("FAIL misaligned_pc: got %h want %h", pc, 32'h104); end
    apply_reset();
  endtask

  task automatic test_wrap();
    int rc;
    logic [31:0] a;
    logic bok;
    do_fetch(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 32'hFC00_0001, rc, a, bok);
    total++; if (a !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr: got %h want %h", a, 32'hFFFF_FFFC); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_pc: got %h want %h", pc, 32'h0); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_req();
    int dc;
    fetch_start = 1'b1;
    @(posedge clk); #1;
    fetch_start = 1'b0;
    @(posedge clk); #1;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL midreq_in_req: got %b want %b", mem_req, 1'b1); end
    dc = done_count;
    #2;
    mem_ready = 1'b1;
    mem_rdata = 32'h1234_5678;
    reset = 1'b1;
    #1;
    total++; if ({pc, ir} !== {32'h0, 32'h0}) begin bad++; $display("FAIL midreq_regs: got %h/%h want 00000000/00000000", pc, ir); end
    total++; if ({mem_req, busy, fetch_done, opcode} !== 9'b0) begin bad++; $display("FAIL midreq_flags: got %b want %b", {mem_req, busy, fetch_done, opcode}, 9'b0); end
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (done_count !== dc) begin bad++; $display("FAIL midreq_no_done: got %0d want %0d", done_count - dc, 0); end
    total++; if ({pc, ir} !== {32'h0, 32'h0}) begin bad++; $display("FAIL midreq_after: got %h/%h want 00000000/00000000", pc, ir); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delayed();
    test_ready_at_limit();
    test_timeout();
    test_redirect();
    test_misaligned();
    test_wrap();
    test_reset_mid_req();
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL sb_pending: got %0d want %0d", sb.size(), 0); end
    total++; if (done_count !== push_count) begin bad++; $display("FAIL sb_done_count: got %0d want %0d", done_count, push_count); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
